seq_issue_ctrl: RTL and testbench

- Instruction buffer and issue sequencer in front of the seq datapath (register file + ALU + send).
- Accepts one instruction per UART receive byte and buffers it in a FIFO.
- Issues instructions to seq one per cycle. Inserts bubbles for the ALU's one-cycle write-back hazard, and holds send instructions until the UART transmitter can accept them.
- Sits between the UART receiver and seq; also sees the UART transmit busy flag.

---
 rtl/seq_issue_ctrl_pkg.sv | 58 +++++
 rtl/seq_issue_ctrl_if.sv | 31 +++
 rtl/seq_issue_ctrl_fifo.sv | 54 +++++
 rtl/seq_issue_ctrl.sv | 115 +++++++++++
 tb/tb_seq_issue_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_issue_ctrl_pkg.sv
// Shared definitions for the seq instruction path: word layout, opcodes,
// issue-sequencer states and decode helpers used by the issue controller.
package seq_issue_ctrl_pkg;

  localparam int SEQ_IN_WIDTH = 8;
  localparam int SEQ_OP_WIDTH = 2;
  localparam int SEQ_RN_WIDTH = 2;

  typedef enum logic [SEQ_OP_WIDTH-1:0] {
    seq_op_push = 2'd0,
    seq_op_add  = 2'd1,
    seq_op_mult = 2'd2,
    seq_op_send = 2'd3
  } seq_op_e;

  typedef enum logic [1:0] {
    ISSUE     = 2'd0,
    SEND_WAIT = 2'd1,
    DRAIN     = 2'd2
  } issue_state_e;

  // op on top, then ra, rb, rc; push carries its immediate in the rb/rc bits.
  typedef struct packed {
    seq_op_e                 op;
    logic [SEQ_RN_WIDTH-1:0] ra;
    logic [SEQ_RN_WIDTH-1:0] rb;
    logic [SEQ_RN_WIDTH-1:0] rc;
  } seq_inst_t;

  typedef struct packed {
    logic                    vld;
    logic [SEQ_RN_WIDTH-1:0] rn;
  } dest_t;

  function automatic dest_t inst_dest(input seq_inst_t inst);
    dest_t d;
    d.vld = 1'b1;
    d.rn  = inst.rc;
    case (inst.op)
      seq_op_push: d.rn  = inst.ra;
      seq_op_send: d.vld = 1'b0;
      default:     d.rn  = inst.rc;
    endcase
    return d;
  endfunction

  function automatic logic reads_reg(input seq_inst_t inst,
                                     input logic [SEQ_RN_WIDTH-1:0] rn);
    logic r;
    case (inst.op)
      seq_op_push: r = 1'b0;
      seq_op_send: r = (inst.ra == rn);
      default:     r = (inst.ra == rn) || (inst.rb == rn);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_issue_ctrl_if.sv
// Bundle between the UART side / seq datapath and the issue controller.
interface seq_issue_ctrl_if #(parameter int DEPTH = 8) ();
  import seq_issue_ctrl_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  // i_rx_valid is a one-cycle strobe with no back-pressure: a byte arriving
  // while the buffer is full is dropped and flagged on the sticky o_ovf.
  // o_inst_valid is likewise a one-cycle strobe; seq must take it that cycle.
  logic [SEQ_IN_WIDTH-1:0] i_rx_data;
  logic                    i_rx_valid;
  logic                    i_run;
  logic                    i_tx_busy;
  logic [SEQ_IN_WIDTH-1:0] o_inst;
  logic                    o_inst_valid;
  logic [LW-1:0]           o_level;
  logic                    o_ovf;
  logic                    o_stall;
  issue_state_e            dbg_state;

  modport master (
    output i_rx_data, i_rx_valid, i_run, i_tx_busy,
    input  o_inst, o_inst_valid, o_level, o_ovf, o_stall, dbg_state
  );

  modport slave (
    input  i_rx_data, i_rx_valid, i_run, i_tx_busy,
    output o_inst, o_inst_valid, o_level, o_ovf, o_stall, dbg_state
  );

endinterface

// File: rtl/seq_issue_ctrl_fifo.sv
// Synchronous FIFO with occupancy count; a write to a full FIFO is accepted
// only when a read happens in the same cycle.
module seq_issue_ctrl_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/seq_issue_ctrl.sv
// Instruction buffer and issue sequencer for seq: buffers rx bytes, issues one
// per cycle, bubbles on write-back hazards and paces sends against the UART.
module seq_issue_ctrl
  import seq_issue_ctrl_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int SEND_TO = 4
) (
  input logic              clk,
  input logic              rst,
  seq_issue_ctrl_if.slave  bus
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(SEND_TO + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(SEND_TO);

  issue_state_e            state, state_nx;
  logic [TW-1:0]           timer, timer_nx;
  dest_t                   sb, sb_nx;
  logic                    issue;
  logic                    stall;
  logic                    full;
  logic                    empty;
  logic [LW-1:0]           level;
  logic [SEQ_IN_WIDTH-1:0] head_raw;
  seq_inst_t               head;
  logic                    hazard;
  logic                    is_send;
  logic [SEQ_IN_WIDTH-1:0] inst_q;
  logic                    inst_valid_q;
  logic                    stall_q;
  logic                    ovf_q;

  seq_issue_ctrl_fifo #(.DEPTH(DEPTH), .WIDTH(SEQ_IN_WIDTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.i_rx_valid),
    .wr_data (bus.i_rx_data),
    .rd_en   (issue),
    .rd_data (head_raw),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign head    = seq_inst_t'(head_raw);
  assign hazard  = sb.vld && reads_reg(head, sb.rn);
  assign is_send = (head.op == seq_op_send);

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    issue    = 1'b0;
    stall    = 1'b0;
    case (state)
      SEND_WAIT: begin
        stall = 1'b1;
        if (bus.i_tx_busy) begin
          state_nx = DRAIN;
        end else begin
          timer_nx = timer - TW'(1);
          if (timer_nx == '0) state_nx = ISSUE;
        end
      end
      ISSUE, DRAIN: begin
        if (bus.i_run && !empty) begin
          if (hazard || (is_send && bus.i_tx_busy)) begin
            stall = 1'b1;
          end else begin
            issue = 1'b1;
            if (is_send) begin
              state_nx = SEND_WAIT;
              timer_nx = TIMER_LOAD;
            end
          end
        end
        // DRAIN only falls back once the transmitter is idle with nothing queued.
        if (state == DRAIN && empty && !bus.i_tx_busy) state_nx = ISSUE;
      end
      default: state_nx = ISSUE;
    endcase
  end

  // Only an issuing cycle leaves a destination behind; any bubble clears it.
  assign sb_nx = issue ? inst_dest(head) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ISSUE;
      timer        <= '0;
      sb           <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      stall_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state        <= state_nx;
      timer        <= timer_nx;
      sb           <= sb_nx;
      inst_valid_q <= issue;
      stall_q      <= stall;
      if (issue) inst_q <= head_raw;
      if (bus.i_rx_valid && full && !issue) ovf_q <= 1'b1;
    end
  end

  assign bus.o_inst       = inst_q;
  assign bus.o_inst_valid = inst_valid_q;
  assign bus.o_level      = level;
  assign bus.o_ovf        = ovf_q;
  assign bus.o_stall      = stall_q;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_seq_issue_ctrl.sv
// Bench for seq_issue_ctrl: directed scenarios then random traffic, every
// cycle compared against a queue-based model of the issue rules.
module tb_seq_issue_ctrl;
  import seq_issue_ctrl_pkg::*;

  localparam int DEPTH   = 8;
  localparam int SEND_TO = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_issue_ctrl_if #(.DEPTH(DEPTH)) bus ();

  seq_issue_ctrl #(.DEPTH(DEPTH), .SEND_TO(SEND_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: buffered bytes, remaining post-send wait, last destination.
  logic [7:0] exp_q[$];
  int         wait_left;
  int         last_dest;
  bit         m_ovf;
  bit         exp_valid;
  bit         exp_stall;
  logic [7:0] exp_inst;

  function automatic bit m_reads(input logic [7:0] h, input int d);
    int op, ra, rb;
    op = int'(h[7:6]);
    ra = int'(h[5:4]);
    rb = int'(h[3:2]);
    if (d < 0) return 1'b0;
    if (op == 0) return 1'b0;
    if (op == 3) return ra == d;
    return (ra == d) || (rb == d);
  endfunction

  function automatic int m_dest(input logic [7:0] h);
    int op;
    op = int'(h[7:6]);
    if (op == 0) return int'(h[5:4]);
    if (op == 3) return -1;
    return int'(h[1:0]);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    wait_left = 0;
    last_dest = -1;
    m_ovf     = 1'b0;
    exp_valid = 1'b0;
    exp_stall = 1'b0;
    exp_inst  = '0;
  endtask

  task automatic model_edge();
    bit         iss;
    bit         stl;
    logic [7:0] h;
    iss = 1'b0;
    stl = 1'b0;
    h   = '0;
    if (wait_left > 0) begin
      stl = 1'b1;
      if (bus.i_tx_busy) wait_left = 0;
      else wait_left = wait_left - 1;
    end else if (bus.i_run && exp_q.size() > 0) begin
      h = exp_q[0];
      if (m_reads(h, last_dest)) stl = 1'b1;
      else if (h[7:6] == 2'd3 && bus.i_tx_busy) stl = 1'b1;
      else iss = 1'b1;
    end
    if (iss) begin
      void'(exp_q.pop_front());
      exp_inst  = h;
      last_dest = m_dest(h);
      if (h[7:6] == 2'd3) wait_left = SEND_TO;
    end else begin
      last_dest = -1;
    end
    if (bus.i_rx_valid) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(bus.i_rx_data);
      else m_ovf = 1'b1;
    end
    exp_valid = iss;
    exp_stall = stl;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("inst_valid", 32'(bus.o_inst_valid), 32'(exp_valid));
    chk("stall", 32'(bus.o_stall), 32'(exp_stall));
    chk("level", 32'(bus.o_level), 32'(exp_q.size()));
    chk("ovf", 32'(bus.o_ovf), 32'(m_ovf));
    if (exp_valid) chk("inst", 32'(bus.o_inst), 32'(exp_inst));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    step();
    idle_inputs();
  endtask

  // Reset is asserted away from any clock edge and checked before one arrives.
  task automatic apply_reset();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.o_inst_valid), 32'd0);
    chk("rst_level", 32'(bus.o_level), 32'd0);
    chk("rst_ovf", 32'(bus.o_ovf), 32'd0);
    chk("rst_stall", 32'(bus.o_stall), 32'd0);
    chk("rst_inst", 32'(bus.o_inst), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(ISSUE));
    model_reset();
    idle_inputs();
    bus.i_run     = 1'b0;
    bus.i_tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int seen;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    bus.i_run     = 1'b0;
    bus.i_tx_busy = 1'b0;
    model_reset();
    #2;
    apply_reset();

    // Single push r1,#5 with issue enabled.
    bus.i_run = 1'b1;
    send_byte(8'h15);
    step();
    chk("t1_valid", 32'(bus.o_inst_valid), 32'd1);
    chk("t1_inst", 32'(bus.o_inst), 32'h15);
    step();
    chk("t1_level", 32'(bus.o_level), 32'd0);

    // push r1,#5 then add r1,r2->r3: one bubble between them.
    bus.i_run = 1'b0;
    send_byte(8'h15);
    send_byte(8'h5B);
    bus.i_run = 1'b1;
    step();
    chk("t2_push", 32'({bus.o_inst_valid, bus.o_stall}), 32'b10);
    step();
    chk("t2_bubble", 32'({bus.o_inst_valid, bus.o_stall}), 32'b01);
    step();
    chk("t2_add", 32'({bus.o_inst_valid, bus.o_stall}), 32'b10);
    step();

    // push r0,#1 then add r2,r3->r1: independent, back to back.
    bus.i_run = 1'b0;
    send_byte(8'h01);
    send_byte(8'h6D);
    bus.i_run = 1'b1;
    step();
    chk("t3_first", 32'({bus.o_inst_valid, bus.o_stall}), 32'b10);
    step();
    chk("t3_second", 32'({bus.o_inst_valid, bus.o_stall}), 32'b10);
    step();

    // Two sends and a push against a busy transmitter, then the send timeout.
    bus.i_run = 1'b0;
    send_byte(8'hD0);
    send_byte(8'hD0);
    send_byte(8'h15);
    bus.i_tx_busy = 1'b1;
    bus.i_run     = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      seen += int'(bus.o_inst_valid);
    end
    chk("t4_held", 32'(seen), 32'd0);
    bus.i_tx_busy = 1'b0;
    step();
    chk("t4_issue", 32'(bus.o_inst_valid), 32'd1);
    bus.i_tx_busy = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen += int'(bus.o_inst_valid);
    end
    chk("t4_second_held", 32'(seen), 32'd0);
    bus.i_tx_busy = 1'b0;
    step();
    chk("t4_second_issue", 32'(bus.o_inst_valid), 32'd1);
    n = 0;
    step();
    while (!bus.o_inst_valid && n < 20) begin
      n++;
      step();
    end
    chk("t5_wait", 32'(n), 32'(SEND_TO));
    chk("t5_next", 32'(bus.o_inst), 32'h15);

    // Overflow with issue disabled, then reset in the middle of traffic.
    bus.i_run = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(8'(8'h20 + i));
    chk("t6_level", 32'(bus.o_level), 32'(DEPTH));
    chk("t6_ovf", 32'(bus.o_ovf), 32'd1);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = 8'h33;
    #2;
    apply_reset();

    // Random traffic, with one extra asynchronous reset part way through.
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.i_rx_valid = ($urandom_range(0, 2) != 0);
      bus.i_rx_data  = 8'($urandom_range(0, 255));
      bus.i_run      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 4) == 0) bus.i_tx_busy = !bus.i_tx_busy;
      step();
      if (cyc == 300) begin
        #2;
        apply_reset();
      end
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
